// File: rtl/acq_frame_streamer_if.sv
// Sample-in / word-out bus of the acquisition frame streamer.
// The master side is the streamer itself: it consumes channel-tagged samples
// and produces framed output words under valid/ready flow control.
interface acq_frame_streamer_if #(
  parameter int SAMPLE_W = 16,
  parameter int CH_W     = 5,
  parameter int OUT_W    = 32
);
  // ADC sample side (no ready: at most one sample per cycle)
  logic [SAMPLE_W-1:0] s_data;
  logic                s_valid;
  logic [CH_W-1:0]     s_ch;

  // Output word stream towards the DMA/packet stage
  logic [OUT_W-1:0]    m_data;
  logic                m_valid;
  logic                m_ready;
  logic                m_frame_last;
  logic                m_last;

  modport master (
    input  s_data, s_valid, s_ch, m_ready,
    output m_data, m_valid, m_frame_last, m_last
  );

  modport slave (
    output s_data, s_valid, s_ch, m_ready,
    input  m_data, m_valid, m_frame_last, m_last
  );
endinterface

// File: rtl/acq_frame_streamer.sv
// Acquisition frame streamer.
// Gathers one sample per channel into a frame, hands complete frames to a
// single holding register and serialises that register word by word onto a
// valid/ready stream. A capture ends after FRAMES accepted frames; frames
// that complete while the holding register is still busy are counted and
// discarded.
module acq_frame_streamer #(
  parameter int NUM_CH   = 22,
  parameter int SAMPLE_W = 16,
  parameter int CH_W     = 5,
  parameter int OUT_W    = 32,
  parameter int FRAMES   = 1000,
  parameter int DROP_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  acq_frame_streamer_if.master  bus,
  input  logic                  i_start,
  input  logic                  i_stop,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DROP_W-1:0]     o_drop_cnt,
  output logic                  o_ch_err
);

  localparam int FRAME_W = NUM_CH * SAMPLE_W;
  localparam int WPF     = (FRAME_W + OUT_W - 1) / OUT_W;
  localparam int PAD_W   = WPF * OUT_W;
  localparam int WIDX_W  = (WPF > 1) ? $clog2(WPF) : 1;
  localparam int FC_W    = $clog2(FRAMES + 1);
  localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DRAIN
  } state_t;

  // Control state
  state_t              r_state;
  logic [NUM_CH-1:0]   r_mask;
  logic [FC_W-1:0]     r_frame_cnt;
  logic [WIDX_W-1:0]   r_word_idx;
  logic                r_hold_full;
  logic                r_frame_last;
  logic                r_m_last;
  logic                r_last_frame;
  logic                r_done;
  logic [DROP_W-1:0]   r_drop_cnt;
  logic                r_ch_err;

  // Data state
  logic [FRAME_W-1:0]  r_frame;
  logic [PAD_W-1:0]    r_hold;

  // Combinational decode
  logic                w_hs;
  logic                w_hs_last;
  logic                w_ch_ok;
  logic                w_wr;
  logic                w_ch_bad;
  logic                w_complete;
  logic                w_hold_free;
  logic                w_load;
  logic                w_drop;
  logic                w_shift;
  logic                w_final;
  logic                w_next_is_last;
  logic [FRAME_W-1:0]  w_frame_next;
  logic [NUM_CH-1:0]   w_mask_next;

  // A word moves when the holding register presents it and downstream takes it.
  assign w_hs      = r_hold_full && bus.m_ready;
  assign w_hs_last = w_hs && r_frame_last;
  assign w_shift   = w_hs && !r_frame_last;

  // Channel indices at or above NUM_CH are not slots of the frame.
  assign w_ch_ok = ({1'b0, bus.s_ch} < NUM_CH_L);

  // In ARMED only a channel-0 sample is taken, so every frame starts aligned
  // to a sweep. stop has priority over any capture activity in its cycle.
  assign w_wr = bus.s_valid && w_ch_ok && !i_stop &&
                ((r_state == ST_CAPTURE) ||
                 ((r_state == ST_ARMED) && (bus.s_ch == '0)));

  assign w_ch_bad = bus.s_valid && !w_ch_ok && !i_stop && (r_state == ST_CAPTURE);

  // Merge the incoming sample into the frame image and the slot mask.
  always_comb begin
    w_frame_next = r_frame;
    w_mask_next  = r_mask;
    if (w_wr) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.s_ch == CH_W'(c)) begin
          w_frame_next[c*SAMPLE_W +: SAMPLE_W] = bus.s_data;
          w_mask_next[c]                       = 1'b1;
        end
      end
    end
  end

  // A frame completes in the cycle its last missing slot is written. The
  // holding register counts as free when its final word leaves this cycle,
  // which lets frames follow each other without a bubble.
  assign w_complete     = w_wr && (&w_mask_next);
  assign w_hold_free    = !r_hold_full || w_hs_last;
  assign w_load         = w_complete && w_hold_free;
  assign w_drop         = w_complete && !w_hold_free;
  assign w_final        = (r_frame_cnt == FC_W'(FRAMES - 1));
  assign w_next_is_last = (r_word_idx == WIDX_W'(WPF - 2));

  // Control path: FSM, capture mask, output sequencing and status counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_mask       <= '0;
      r_frame_cnt  <= '0;
      r_word_idx   <= '0;
      r_hold_full  <= 1'b0;
      r_frame_last <= 1'b0;
      r_m_last     <= 1'b0;
      r_last_frame <= 1'b0;
      r_done       <= 1'b0;
      r_drop_cnt   <= '0;
      r_ch_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // Output word sequencing
      if (w_hs) begin
        if (r_frame_last) begin
          r_hold_full  <= 1'b0;
          r_frame_last <= 1'b0;
          r_m_last     <= 1'b0;
        end else begin
          r_word_idx   <= r_word_idx + WIDX_W'(1);
          r_frame_last <= w_next_is_last;
          r_m_last     <= w_next_is_last && r_last_frame;
        end
      end

      // A completed frame enters the holding register (overrides the release above)
      if (w_load) begin
        r_hold_full  <= 1'b1;
        r_word_idx   <= '0;
        r_frame_last <= (WPF == 1);
        r_m_last     <= (WPF == 1) && w_final;
        r_last_frame <= w_final;
        r_frame_cnt  <= r_frame_cnt + FC_W'(1);
      end

      // Slot mask restarts after every completed frame, kept or dropped
      if (w_wr) begin
        r_mask <= w_complete ? '0 : w_mask_next;
      end

      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      end

      if (w_ch_bad) begin
        r_ch_err <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (i_start && !i_stop) begin
            r_state     <= ST_ARMED;
            r_frame_cnt <= '0;
            r_mask      <= '0;
            r_ch_err    <= 1'b0;
            r_drop_cnt  <= '0;
          end
        end
        ST_ARMED: begin
          if (w_load && w_final) begin
            r_state <= ST_DRAIN;
          end else if (w_wr) begin
            r_state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (w_load && w_final) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_hs_last) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Abort: drop whatever is pending, silently
      if (i_stop && (r_state != ST_IDLE)) begin
        r_state      <= ST_IDLE;
        r_mask       <= '0;
        r_hold_full  <= 1'b0;
        r_frame_last <= 1'b0;
        r_m_last     <= 1'b0;
        r_last_frame <= 1'b0;
      end
    end
  end

  // Frame assembly and output holding register; pure data, validity lives in control.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_frame <= w_frame_next;
    end
    if (w_load) begin
      r_hold <= PAD_W'(w_frame_next);
    end else if (w_shift) begin
      r_hold <= r_hold >> OUT_W;
    end
  end

  // Word 0 sits in the low bits of the holding register and each accepted
  // word shifts the next one down; data is forced to zero when nothing is valid.
  assign bus.m_data       = r_hold_full ? r_hold[OUT_W-1:0] : '0;
  assign bus.m_valid      = r_hold_full;
  assign bus.m_frame_last = r_frame_last;
  assign bus.m_last       = r_m_last;

  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = r_done;
  assign o_drop_cnt = r_drop_cnt;
  assign o_ch_err   = r_ch_err;

endmodule

// File: tb/tb_acq_frame_streamer.sv
// Directed bench for acq_frame_streamer: a 22ch x 16b instance capturing two
// frames per start, plus a 3ch x 12b / 16b-word instance for padding.
module tb_acq_frame_streamer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  acq_frame_streamer_if #(.SAMPLE_W(16), .CH_W(5), .OUT_W(32)) bus_a ();
  acq_frame_streamer_if #(.SAMPLE_W(12), .CH_W(2), .OUT_W(16)) bus_b ();

  logic        start_a, stop_a, busy_a, done_a, cherr_a;
  logic [15:0] drop_a;
  logic        start_b, stop_b, busy_b, done_b, cherr_b;
  logic [15:0] drop_b;

  acq_frame_streamer #(
    .NUM_CH(22), .SAMPLE_W(16), .CH_W(5), .OUT_W(32), .FRAMES(2), .DROP_W(16)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .i_start(start_a), .i_stop(stop_a),
    .o_busy(busy_a), .o_done(done_a), .o_drop_cnt(drop_a), .o_ch_err(cherr_a)
  );

  acq_frame_streamer #(
    .NUM_CH(3), .SAMPLE_W(12), .CH_W(2), .OUT_W(16), .FRAMES(1), .DROP_W(16)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .i_start(start_b), .i_stop(stop_b),
    .o_busy(busy_b), .o_done(done_b), .o_drop_cnt(drop_b), .o_ch_err(cherr_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Word monitor for instance A: {m_last, m_frame_last, m_data} per handshake
  logic [33:0] q[$];
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_hs_cyc = -1;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus_a.m_valid && bus_a.m_ready) begin
      q.push_back({bus_a.m_last, bus_a.m_frame_last, bus_a.m_data});
      if (bus_a.m_last) last_hs_cyc = cyc;
    end
    if (done_a) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  function automatic logic [15:0] val(int f, int c);
    return 16'(f * 4096 + 2560 + c);
  endfunction

  // Expected monitor entry for word k of sweep f (fin: last frame of capture)
  function automatic logic [33:0] exp_entry(int f, int k, bit fin);
    logic [31:0] w;
    w = {val(f, 2*k+1), val(f, 2*k)};
    return {fin && (k == 10), (k == 10), w};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_range(int f, int lo, int hi);
    for (int c = lo; c <= hi; c++) begin
      bus_a.s_valid = 1'b1;
      bus_a.s_ch    = 5'(c);
      bus_a.s_data  = val(f, c);
      tick();
    end
    bus_a.s_valid = 1'b0;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic pulse_stop_a();
    stop_a = 1'b1;
    tick();
    stop_a = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done_cnt > d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if ({bus_a.m_valid, bus_a.m_frame_last, bus_a.m_last, busy_a, done_a, cherr_a} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags_a: got %b want 000000",
               {bus_a.m_valid, bus_a.m_frame_last, bus_a.m_last, busy_a, done_a, cherr_a});
    end
    n_tests++;
    if (bus_a.m_data !== 32'h0 || drop_a !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_data_a: got data=%h drop=%h want 0/0", bus_a.m_data, drop_a);
    end
    n_tests++;
    if ({bus_b.m_valid, busy_b, done_b, bus_b.m_data} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_b: got %h want 0", {bus_b.m_valid, busy_b, done_b, bus_b.m_data});
    end
  endtask

  task automatic test_basic();
    bit ok;
    q.delete();
    bus_a.m_ready = 1'b1;
    pulse_start_a();
    n_tests++;
    if (busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL t1_busy: got %b want 1", busy_a);
    end
    send_range(0, 0, 21);
    n_tests++;
    if (bus_a.m_valid !== 1'b1 || bus_a.m_data !== exp_entry(0, 0, 0)[31:0]) begin
      n_fail++;
      $display("FAIL t1_latency: got v=%b d=%h want v=1 d=%h",
               bus_a.m_valid, bus_a.m_data, exp_entry(0, 0, 0)[31:0]);
    end
    send_range(1, 0, 21);
    wait_done(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL t1_done: got timeout want done pulse");
    end
    n_tests++;
    if (q.size() != 22) begin
      n_fail++;
      $display("FAIL t1_count: got %0d words want 22", q.size());
    end
    for (int i = 0; i < 22; i++) begin
      n_tests++;
      if (i >= q.size() || q[i] !== exp_entry(i / 11, i % 11, i >= 11)) begin
        n_fail++;
        $display("FAIL t1_word%0d: got %h want %h", i,
                 (i < q.size()) ? q[i] : 34'h0, exp_entry(i / 11, i % 11, i >= 11));
      end
    end
    n_tests++;
    if (done_cyc != last_hs_cyc + 1) begin
      n_fail++;
      $display("FAIL t1_done_timing: got cycle %0d want %0d", done_cyc, last_hs_cyc + 1);
    end
    tick();
    n_tests++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_idle: got busy=%b done=%b want 0/0", busy_a, done_a);
    end
  endtask

  task automatic test_align();
    bit ok;
    q.delete();
    bus_a.m_ready = 1'b1;
    pulse_start_a();
    send_range(7, 5, 21);
    n_tests++;
    if (bus_a.m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t2_armed_ignore: got m_valid=%b want 0", bus_a.m_valid);
    end
    send_range(2, 0, 21);
    send_range(3, 0, 21);
    wait_done(ok);
    n_tests++;
    if (!ok || q.size() != 22) begin
      n_fail++;
      $display("FAIL t2_done: got ok=%b words=%0d want 1/22", ok, q.size());
    end
    for (int i = 0; i < 22; i++) begin
      n_tests++;
      if (i >= q.size() || q[i] !== exp_entry(2 + i / 11, i % 11, i >= 11)) begin
        n_fail++;
        $display("FAIL t2_word%0d: got %h want %h", i,
                 (i < q.size()) ? q[i] : 34'h0, exp_entry(2 + i / 11, i % 11, i >= 11));
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] held;
    q.delete();
    bus_a.m_ready = 1'b0;
    pulse_start_a();
    send_range(0, 0, 21);
    held = bus_a.m_data;
    n_tests++;
    if (bus_a.m_valid !== 1'b1 || held !== exp_entry(0, 0, 0)[31:0]) begin
      n_fail++;
      $display("FAIL t3_first: got v=%b d=%h want v=1 d=%h", bus_a.m_valid, held,
               exp_entry(0, 0, 0)[31:0]);
    end
    send_range(1, 0, 21);
    send_range(2, 0, 21);
    n_tests++;
    if (bus_a.m_valid !== 1'b1 || bus_a.m_data !== exp_entry(0, 0, 0)[31:0]) begin
      n_fail++;
      $display("FAIL t3_stable: got v=%b d=%h want v=1 d=%h", bus_a.m_valid, bus_a.m_data,
               exp_entry(0, 0, 0)[31:0]);
    end
    n_tests++;
    if (drop_a !== 16'd2) begin
      n_fail++;
      $display("FAIL t3_drop_cnt: got %0d want 2", drop_a);
    end
    bus_a.m_ready = 1'b1;
    send_range(3, 0, 21);
    wait_done(ok);
    n_tests++;
    if (!ok || q.size() != 22) begin
      n_fail++;
      $display("FAIL t3_done: got ok=%b words=%0d want 1/22", ok, q.size());
    end
    for (int i = 0; i < 22; i++) begin
      n_tests++;
      if (i >= q.size() || q[i] !== exp_entry((i < 11) ? 0 : 3, i % 11, i >= 11)) begin
        n_fail++;
        $display("FAIL t3_word%0d: got %h want %h", i,
                 (i < q.size()) ? q[i] : 34'h0, exp_entry((i < 11) ? 0 : 3, i % 11, i >= 11));
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    q.delete();
    bus_a.m_ready = 1'b0;
    pulse_start_a();
    send_range(4, 0, 21);
    send_range(5, 0, 10);
    // Release the stream so the last word of frame 4 leaves with channel 21
    bus_a.m_ready = 1'b1;
    send_range(5, 11, 21);
    n_tests++;
    if (drop_a !== 16'd0) begin
      n_fail++;
      $display("FAIL t4_no_drop: got drop_cnt=%0d want 0", drop_a);
    end
    n_tests++;
    if (bus_a.m_valid !== 1'b1 || bus_a.m_data !== exp_entry(5, 0, 1)[31:0] ||
        bus_a.m_frame_last !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_no_bubble: got v=%b d=%h fl=%b want v=1 d=%h fl=0", bus_a.m_valid,
               bus_a.m_data, bus_a.m_frame_last, exp_entry(5, 0, 1)[31:0]);
    end
    wait_done(ok);
    n_tests++;
    if (!ok || q.size() != 22) begin
      n_fail++;
      $display("FAIL t4_done: got ok=%b words=%0d want 1/22", ok, q.size());
    end
    for (int i = 0; i < 22; i++) begin
      n_tests++;
      if (i >= q.size() || q[i] !== exp_entry(4 + i / 11, i % 11, i >= 11)) begin
        n_fail++;
        $display("FAIL t4_word%0d: got %h want %h", i,
                 (i < q.size()) ? q[i] : 34'h0, exp_entry(4 + i / 11, i % 11, i >= 11));
      end
    end
  endtask

  task automatic test_padding();
    logic [11:0] smp [3];
    logic [15:0] want [3];
    smp[0] = 12'hABC; smp[1] = 12'h123; smp[2] = 12'h9F5;
    want[0] = 16'h3ABC; want[1] = 16'hF512; want[2] = 16'h0009;
    bus_b.m_ready = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus_b.s_valid = 1'b1;
      bus_b.s_ch    = 2'(c);
      bus_b.s_data  = smp[c];
      tick();
    end
    bus_b.s_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (bus_b.m_valid !== 1'b1 || bus_b.m_data !== want[k] ||
          bus_b.m_frame_last !== (k == 2) || bus_b.m_last !== (k == 2)) begin
        n_fail++;
        $display("FAIL t5_word%0d: got v=%b d=%h fl=%b l=%b want v=1 d=%h fl=l=%b", k,
                 bus_b.m_valid, bus_b.m_data, bus_b.m_frame_last, bus_b.m_last, want[k], k == 2);
      end
      tick();
    end
    n_tests++;
    if (done_b !== 1'b1 || bus_b.m_valid !== 1'b0 || busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_done: got done=%b v=%b busy=%b want 1/0/0", done_b, bus_b.m_valid, busy_b);
    end
  endtask

  task automatic test_ch_err();
    bit ok;
    q.delete();
    bus_a.m_ready = 1'b1;
    pulse_start_a();
    send_range(6, 0, 10);
    bus_a.s_valid = 1'b1;
    bus_a.s_ch    = 5'd25;
    bus_a.s_data  = 16'hDEAD;
    tick();
    send_range(6, 11, 21);
    n_tests++;
    if (cherr_a !== 1'b1) begin
      n_fail++;
      $display("FAIL t6_ch_err_set: got %b want 1", cherr_a);
    end
    send_range(7, 0, 21);
    wait_done(ok);
    n_tests++;
    if (!ok || q.size() != 22) begin
      n_fail++;
      $display("FAIL t6_done: got ok=%b words=%0d want 1/22", ok, q.size());
    end
    for (int i = 0; i < 22; i++) begin
      n_tests++;
      if (i >= q.size() || q[i] !== exp_entry(6 + i / 11, i % 11, i >= 11)) begin
        n_fail++;
        $display("FAIL t6_word%0d: got %h want %h", i,
                 (i < q.size()) ? q[i] : 34'h0, exp_entry(6 + i / 11, i % 11, i >= 11));
      end
    end
    n_tests++;
    if (cherr_a !== 1'b1) begin
      n_fail++;
      $display("FAIL t6_ch_err_sticky: got %b want 1", cherr_a);
    end
    pulse_start_a();
    n_tests++;
    if (cherr_a !== 1'b0 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL t6_ch_err_clear: got err=%b busy=%b want 0/1", cherr_a, busy_a);
    end
    pulse_stop_a();
  endtask

  task automatic test_abort();
    int d0;
    d0 = done_cnt;
    bus_a.m_ready = 1'b1;
    pulse_start_a();
    send_range(8, 0, 10);
    pulse_stop_a();
    n_tests++;
    if (busy_a !== 1'b0 || bus_a.m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t7_stop_midframe: got busy=%b v=%b want 0/0", busy_a, bus_a.m_valid);
    end
    bus_a.m_ready = 1'b0;
    pulse_start_a();
    send_range(8, 0, 21);
    n_tests++;
    if (bus_a.m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL t7_pre_stop_valid: got %b want 1", bus_a.m_valid);
    end
    pulse_stop_a();
    tick();
    tick();
    n_tests++;
    if (bus_a.m_valid !== 1'b0 || busy_a !== 1'b0 || done_cnt != d0) begin
      n_fail++;
      $display("FAIL t7_stop_word: got v=%b busy=%b dones=%0d want 0/0/%0d",
               bus_a.m_valid, busy_a, done_cnt, d0);
    end
    pulse_start_a();
    send_range(9, 0, 21);
    n_tests++;
    if (bus_a.m_valid !== 1'b1 || bus_a.m_data !== exp_entry(9, 0, 0)[31:0]) begin
      n_fail++;
      $display("FAIL t7_pre_rst_valid: got v=%b d=%h want v=1 d=%h", bus_a.m_valid,
               bus_a.m_data, exp_entry(9, 0, 0)[31:0]);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus_a.m_valid !== 1'b0 || busy_a !== 1'b0 || bus_a.m_data !== 32'h0 || done_a !== 1'b0) begin
      n_fail++;
      $display("FAIL t7_async_rst: got v=%b busy=%b d=%h done=%b want 0/0/0/0",
               bus_a.m_valid, busy_a, bus_a.m_data, done_a);
    end
    tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if (busy_a !== 1'b0 || bus_a.m_valid !== 1'b0 || done_cnt != d0) begin
      n_fail++;
      $display("FAIL t7_after_rst: got busy=%b v=%b dones=%0d want 0/0/%0d",
               busy_a, bus_a.m_valid, done_cnt, d0);
    end
  endtask

  initial begin
    start_a = 1'b0; stop_a = 1'b0;
    start_b = 1'b0; stop_b = 1'b0;
    bus_a.s_valid = 1'b0; bus_a.s_ch = '0; bus_a.s_data = '0; bus_a.m_ready = 1'b0;
    bus_b.s_valid = 1'b0; bus_b.s_ch = '0; bus_b.s_data = '0; bus_b.m_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_basic();
    test_align();
    test_backpressure();
    test_back_to_back();
    test_padding();
    test_ch_err();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
